// File: rtl/sub_pkg.sv
// Shared types and constants for the subtitle text controller.
// Holds the FSM state encoding, control codes and printable range.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLR_LINE,
        CLR_ALL
    } state_t;

    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_FF = 8'h0C;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    localparam logic [7:0] DEF_BLANK = 8'h20;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/sub_text_ctrl_if.sv
// Character handshake and subtitle RAM write bus of sub_text_ctrl.
// master drives characters and observes the RAM port; slave is the controller.
interface sub_text_ctrl_if;
    import sub_pkg::*;

    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       clear_req;
    logic       vblnk_in;
    logic       buf_we;
    logic [7:0] buf_addr;
    logic [7:0] buf_data;
    logic [7:0] cursor_xy;
    logic       busy;

    modport master (
        output char_data,
        output char_valid,
        output clear_req,
        output vblnk_in,
        input  char_ready,
        input  buf_we,
        input  buf_addr,
        input  buf_data,
        input  cursor_xy,
        input  busy
    );

    modport slave (
        input  char_data,
        input  char_valid,
        input  clear_req,
        input  vblnk_in,
        output char_ready,
        output buf_we,
        output buf_addr,
        output buf_data,
        output cursor_xy,
        output busy
    );

endinterface

// File: rtl/sub_cursor.sv
// Row/column cursor register pair for the subtitle buffer.
// Wraps against COLS-1 / ROWS-1, not the 4-bit overflow.
module sub_cursor
    import sub_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROWS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       cr,
    input  logic       nl,
    input  logic       home,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] xy,
    output logic       at_eol
);

    localparam logic [3:0] COL_MAX = 4'(COLS - 1);
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

    logic [3:0] row_next;

    assign row_next = (row == ROW_MAX) ? 4'd0 : row + 4'd1;
    assign xy       = {row, col};
    assign at_eol   = (col == COL_MAX);

    // Cursor update; home beats newline beats CR beats inc/dec.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (home) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (nl) begin
            row <= row_next;
            col <= 4'd0;
        end else if (cr) begin
            col <= 4'd0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                row <= row_next;
                col <= 4'd0;
            end else begin
                col <= col + 4'd1;
            end
        end else if (dec && (col != 4'd0)) begin
            col <= col - 4'd1;
        end
    end

endmodule

// File: rtl/sub_text_ctrl.sv
// Subtitle character-stream controller owning the char RAM write port.
// Optional SUB_VBLANK_GATE_EN: RAM writes only while vblnk_in is high.
module sub_text_ctrl
    import sub_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter int         ROWS       = 16,
    parameter logic [7:0] BLANK_CHAR = DEF_BLANK
) (
    input  logic            clk,
    input  logic            rst,
    sub_text_ctrl_if.slave  bus
);

    localparam logic [3:0] COL_MAX = 4'(COLS - 1);
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic       wrap_q, wrap_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_bs_q, wr_bs_d;
    logic [3:0] clr_row_q, clr_row_d;
    logic [3:0] clr_col_q, clr_col_d;
    logic       fin_q, fin_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;

    logic       cur_inc, cur_dec, cur_cr, cur_nl, cur_home;
    logic [3:0] cur_row, cur_col;
    logic [7:0] cur_xy;
    logic       cur_eol;

    logic       gate_ok;
    logic       accept;
    logic       do_wr;
    logic [7:0] src_data;
    logic       src_bs;
    logic [7:0] c;

`ifdef SUB_VBLANK_GATE_EN
    assign gate_ok = bus.vblnk_in;
`else
    logic unused_vblnk;
    assign unused_vblnk = bus.vblnk_in;
    assign gate_ok      = 1'b1;
`endif

    assign accept = bus.char_valid && ready_q;
    assign c      = bus.char_data;

    sub_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk    (clk),
        .rst    (rst),
        .inc    (cur_inc),
        .dec    (cur_dec),
        .cr     (cur_cr),
        .nl     (cur_nl),
        .home   (cur_home),
        .row    (cur_row),
        .col    (cur_col),
        .xy     (cur_xy),
        .at_eol (cur_eol)
    );

    // Next-state, clear sequencing and registered-output next values.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        wrap_d    = wrap_q;
        wr_data_d = wr_data_q;
        wr_bs_d   = wr_bs_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        fin_d     = fin_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        cur_inc   = 1'b0;
        cur_dec   = 1'b0;
        cur_cr    = 1'b0;
        cur_nl    = 1'b0;
        cur_home  = 1'b0;
        do_wr     = 1'b0;
        src_data  = wr_data_q;
        src_bs    = wr_bs_q;

        if (bus.clear_req) begin
            state_d   = CLR_ALL;
            clr_row_d = 4'd0;
            clr_col_d = 4'd0;
            fin_d     = 1'b0;
            pend_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_print(c): begin
                                wr_data_d = c;
                                wr_bs_d   = 1'b0;
                                src_data  = c;
                                src_bs    = 1'b0;
                                state_d   = WRITE;
                                do_wr     = gate_ok;
                                pend_d    = !gate_ok;
                            end
                            (c == CODE_BS): begin
                                if (cur_col != 4'd0) begin
                                    wr_data_d = BLANK_CHAR;
                                    wr_bs_d   = 1'b1;
                                    src_data  = BLANK_CHAR;
                                    src_bs    = 1'b1;
                                    state_d   = WRITE;
                                    do_wr     = gate_ok;
                                    pend_d    = !gate_ok;
                                end
                            end
                            (c == CODE_CR): begin
                                cur_cr = 1'b1;
                            end
                            (c == CODE_LF): begin
                                cur_nl    = 1'b1;
                                state_d   = CLR_LINE;
                                clr_col_d = 4'd0;
                                fin_d     = 1'b0;
                            end
                            (c == CODE_FF): begin
                                state_d   = CLR_ALL;
                                clr_row_d = 4'd0;
                                clr_col_d = 4'd0;
                                fin_d     = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    if (pend_q) begin
                        if (gate_ok) begin
                            do_wr  = 1'b1;
                            pend_d = 1'b0;
                        end
                    end else begin
                        state_d   = wrap_q ? CLR_LINE : IDLE;
                        clr_col_d = 4'd0;
                        fin_d     = 1'b0;
                    end
                end
                CLR_LINE: begin
                    if (fin_q) begin
                        state_d = IDLE;
                    end else if (gate_ok) begin
                        we_d   = 1'b1;
                        addr_d = {cur_row, clr_col_q};
                        data_d = BLANK_CHAR;
                        if (clr_col_q == COL_MAX) begin
                            fin_d = 1'b1;
                        end else begin
                            clr_col_d = clr_col_q + 4'd1;
                        end
                    end
                end
                CLR_ALL: begin
                    if (fin_q) begin
                        state_d  = IDLE;
                        cur_home = 1'b1;
                    end else if (gate_ok) begin
                        we_d   = 1'b1;
                        addr_d = {clr_row_q, clr_col_q};
                        data_d = BLANK_CHAR;
                        if (clr_col_q == COL_MAX) begin
                            if (clr_row_q == ROW_MAX) begin
                                fin_d = 1'b1;
                            end else begin
                                clr_col_d = 4'd0;
                                clr_row_d = clr_row_q + 4'd1;
                            end
                        end else begin
                            clr_col_d = clr_col_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d   = CLR_ALL;
                    clr_row_d = 4'd0;
                    clr_col_d = 4'd0;
                    fin_d     = 1'b0;
                end
            endcase
        end

        if (do_wr) begin
            we_d   = 1'b1;
            data_d = src_data;
            if (src_bs) begin
                addr_d  = {cur_row, cur_col - 4'd1};
                cur_dec = 1'b1;
                wrap_d  = 1'b0;
            end else begin
                addr_d  = cur_xy;
                cur_inc = 1'b1;
                wrap_d  = cur_eol;
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CLR_LINE) || (state_d == CLR_ALL);
    end

    // State and output registers; reset starts a full-buffer clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLR_ALL;
            pend_q    <= 1'b0;
            wrap_q    <= 1'b0;
            wr_data_q <= 8'd0;
            wr_bs_q   <= 1'b0;
            clr_row_q <= 4'd0;
            clr_col_q <= 4'd0;
            fin_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            wrap_q    <= wrap_d;
            wr_data_q <= wr_data_d;
            wr_bs_q   <= wr_bs_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            fin_q     <= fin_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.char_ready = ready_q;
    assign bus.buf_we     = we_q;
    assign bus.buf_addr   = addr_q;
    assign bus.buf_data   = data_q;
    assign bus.cursor_xy  = cur_xy;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sub_text_ctrl.sv
// Directed testbench for sub_text_ctrl with a write scoreboard.
// Expected {addr,data} pairs are queued at stimulus time and popped per write.
module tb_sub_text_ctrl;
    import sub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sub_text_ctrl_if bus ();

    sub_text_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.buf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 16'(bus.buf_we), 16'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", {bus.buf_addr, bus.buf_data}, mon_e);
            end
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_clear_all();
        for (int i = 0; i < 256; i++) begin
            push_wr(8'(i), 8'h20);
        end
    endtask

    task automatic send(input logic [7:0] ch);
        int n = 0;
        while (bus.char_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 16'(bus.char_ready), 16'h1);
        bus.char_data  = ch;
        bus.char_valid = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(bus.char_ready === 1'b1 && exp_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 16'(bus.char_ready === 1'b1 && exp_q.size() == 0), 16'h1);
    endtask

    initial begin
        int n;
        bus.char_data  = 8'h00;
        bus.char_valid = 1'b0;
        bus.clear_req  = 1'b0;
        bus.vblnk_in   = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_we", 16'(bus.buf_we), 16'h0);
        check("rst_addr", 16'(bus.buf_addr), 16'h0);
        check("rst_data", 16'(bus.buf_data), 16'h0);
        check("rst_cursor", 16'(bus.cursor_xy), 16'h0);
        check("rst_ready", 16'(bus.char_ready), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h1);

        push_clear_all();
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.char_ready !== 1'b1 && n < 400);
        check("ready_cycle", 16'(n), 16'd257);
        check("init_all_written", 16'(exp_q.size()), 16'h0);
        check("init_cursor", 16'(bus.cursor_xy), 16'h00);
        check("init_busy", 16'(bus.busy), 16'h0);

        push_wr(8'h00, 8'h41);
        send(8'h41);
        push_wr(8'h01, 8'h42);
        send(8'h42);
        wait_idle("ab_idle");
        check("ab_cursor", 16'(bus.cursor_xy), 16'h02);

        for (int i = 2; i < 15; i++) begin
            push_wr(8'(i), 8'h61);
            send(8'h61);
        end
        wait_idle("fill_idle");
        check("fill_cursor", 16'(bus.cursor_xy), 16'h0F);

        push_wr(8'h0F, 8'h5A);
        for (int i = 0; i < 16; i++) begin
            push_wr(8'(8'h10 + i), 8'h20);
        end
        send(8'h5A);
        @(negedge clk);
        check("wrap_busy", 16'(bus.busy), 16'h1);
        check("wrap_not_ready", 16'(bus.char_ready), 16'h0);
        wait_idle("wrap_idle");
        check("wrap_cursor", 16'(bus.cursor_xy), 16'h10);
        check("wrap_busy_done", 16'(bus.busy), 16'h0);

        push_wr(8'h10, 8'h78);
        send(8'h78);
        push_wr(8'h11, 8'h79);
        send(8'h79);
        push_wr(8'h12, 8'h7A);
        send(8'h7A);
        push_wr(8'h12, 8'h20);
        send(CODE_BS);
        wait_idle("bs_idle");
        check("bs_cursor", 16'(bus.cursor_xy), 16'h12);

        send(CODE_CR);
        wait_idle("cr_idle");
        check("cr_cursor", 16'(bus.cursor_xy), 16'h10);

        send(CODE_BS);
        repeat (4) @(negedge clk);
        check("bs0_cursor", 16'(bus.cursor_xy), 16'h10);
        check("bs0_ready", 16'(bus.char_ready), 16'h1);

        send(8'h01);
        repeat (3) @(negedge clk);
        check("other_cursor", 16'(bus.cursor_xy), 16'h10);

        for (int i = 0; i < 16; i++) begin
            push_wr(8'(8'h20 + i), 8'h20);
        end
        send(CODE_LF);
        wait_idle("lf_idle");
        check("lf_cursor", 16'(bus.cursor_xy), 16'h20);

        for (int i = 0; i < 6; i++) begin
            push_wr(8'(8'h30 + i), 8'h20);
        end
        send(CODE_LF);
        n = 0;
        while (!(bus.buf_we === 1'b1 && bus.buf_addr == 8'h35) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_at_35", bus.buf_addr, 16'h35);
        check("abort_busy", 16'(bus.busy), 16'h1);
        push_clear_all();
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        wait_idle("abort_idle");
        check("abort_cursor", 16'(bus.cursor_xy), 16'h00);

        push_clear_all();
        bus.char_data  = 8'h51;
        bus.char_valid = 1'b1;
        bus.clear_req  = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
        bus.clear_req  = 1'b0;
        wait_idle("coinc_idle");
        check("coinc_cursor", 16'(bus.cursor_xy), 16'h00);

        push_wr(8'h00, 8'h43);
        send(8'h43);
        push_clear_all();
        send(CODE_FF);
        wait_idle("ff_idle");
        check("ff_cursor", 16'(bus.cursor_xy), 16'h00);

`ifdef SUB_VBLANK_GATE_EN
        bus.vblnk_in = 1'b0;
        push_wr(8'h00, 8'h41);
        send(8'h41);
        repeat (10) @(negedge clk);
        #1;
        check("gate_hold", 16'(exp_q.size()), 16'h1);
        check("gate_not_ready", 16'(bus.char_ready), 16'h0);
        @(negedge clk);
        bus.vblnk_in = 1'b1;
        @(negedge clk);
        #1;
        check("gate_release", 16'(exp_q.size()), 16'h0);
        wait_idle("gate_idle");
        check("gate_cursor", 16'(bus.cursor_xy), 16'h01);
`endif

        repeat (2) @(negedge clk);
        check("final_queue", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
